// File: rtl/lzrw1_stream_parser.sv
// LZRW1 stream parser: splits a raw compressed byte stream into control-word-tagged
// items (literal byte or 16-bit copy word) for the decompressor's valid/busy input port.
module lzrw1_stream_parser #(
  parameter int unsigned CW_BITS = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_in_valid,
  input  logic             byte_in_last,
  output logic             byte_in_ready,
  input  logic             restart,
  output logic [15:0]      data_out,
  output logic             control_word_out,
  output logic             data_out_valid,
  input  logic             decompressor_busy,
  output logic [CNT_W-1:0] item_count,
  output logic             stream_done,
  output logic             format_error
);

  localparam int unsigned IdxW = $clog2(CW_BITS + 1);

  typedef enum logic [2:0] {
    StCwLo,
    StCwHi,
    StItemB0,
    StItemB1,
    StHold,
    StDone,
    StError
  } state_e;

  state_e          state_q;
  logic [15:0]     cw_q;      // shifted right once per item, so bit 0 is the current flag
  logic [IdxW-1:0] idx_q;
  logic            last_q;    // the held item's final byte carried last

  logic byte_fire;
  logic item_fire;

  assign byte_fire = byte_in_valid && byte_in_ready;
  assign item_fire = data_out_valid && !decompressor_busy;

  assign byte_in_ready = !reset &&
                         (state_q inside {StCwLo, StCwHi, StItemB0, StItemB1});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= StCwLo;
      cw_q             <= '0;
      idx_q            <= '0;
      last_q           <= 1'b0;
      data_out         <= '0;
      control_word_out <= 1'b0;
      data_out_valid   <= 1'b0;
      item_count       <= '0;
      stream_done      <= 1'b0;
      format_error     <= 1'b0;
    end else if (restart) begin
      // Any held item is dropped; the next byte is a fresh control word.
      state_q        <= StCwLo;
      idx_q          <= '0;
      last_q         <= 1'b0;
      data_out_valid <= 1'b0;
      item_count     <= '0;
      stream_done    <= 1'b0;
      format_error   <= 1'b0;
    end else begin
      unique case (state_q)
        StCwLo: begin
          if (byte_fire) begin
            cw_q[7:0] <= byte_in;
            if (byte_in_last) begin
              state_q      <= StError;
              format_error <= 1'b1;
            end else begin
              state_q <= StCwHi;
            end
          end
        end
        StCwHi: begin
          if (byte_fire) begin
            cw_q[15:8] <= byte_in;
            idx_q      <= '0;
            if (byte_in_last) begin
              state_q      <= StError;
              format_error <= 1'b1;
            end else begin
              state_q <= StItemB0;
            end
          end
        end
        StItemB0: begin
          if (byte_fire) begin
            if (!cw_q[0]) begin
              data_out         <= {8'h00, byte_in};
              control_word_out <= 1'b0;
              data_out_valid   <= 1'b1;
              last_q           <= byte_in_last;
              state_q          <= StHold;
            end else begin
              data_out[15:8] <= byte_in;
              if (byte_in_last) begin
                state_q      <= StError;
                format_error <= 1'b1;
              end else begin
                state_q <= StItemB1;
              end
            end
          end
        end
        StItemB1: begin
          if (byte_fire) begin
            data_out[7:0]    <= byte_in;
            control_word_out <= 1'b1;
            data_out_valid   <= 1'b1;
            last_q           <= byte_in_last;
            state_q          <= StHold;
          end
        end
        StHold: begin
          if (item_fire) begin
            data_out_valid <= 1'b0;
            item_count     <= item_count + CNT_W'(1);
            if (last_q) begin
              state_q     <= StDone;
              stream_done <= 1'b1;
            end else begin
              cw_q  <= cw_q >> 1;
              idx_q <= idx_q + IdxW'(1);
              if (idx_q == IdxW'(CW_BITS - 1)) begin
                state_q <= StCwLo;
              end else begin
                state_q <= StItemB0;
              end
            end
          end
        end
        StDone:  state_q <= StDone;
        StError: state_q <= StError;
        default: state_q <= StError;
      endcase
    end
  end

endmodule
